// File: rtl/hdmi_pkg.sv
// Shared timing defaults, horizontal state encoding, pattern selects and colour-bar table
// for the HDMI video timing generator (test patterns built only with TEST_PATTERN_EN).
package hdmi_pkg;

   localparam int CW = 11;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FP     = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BP     = 2'd3
   } h_state_e;

   localparam logic [1:0] PAT_BARS  = 2'b00;
   localparam logic [1:0] PAT_GRAD  = 2'b01;
   localparam logic [1:0] PAT_CHECK = 2'b10;
   localparam logic [1:0] PAT_WHITE = 2'b11;

   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   // Bounds are cumulative phase ends, so a zero-length phase never matches.
   function automatic h_state_e phase_of(input logic [CW-1:0] cnt,
                                         input logic [CW-1:0] end_act,
                                         input logic [CW-1:0] end_fp,
                                         input logic [CW-1:0] end_sync);
      if (cnt < end_act)       return ST_ACTIVE;
      else if (cnt < end_fp)   return ST_FP;
      else if (cnt < end_sync) return ST_SYNC;
      return ST_BP;
   endfunction

endpackage

// File: rtl/tpg_pattern.sv
// Internal test pattern source: bar-width counter, per-frame pattern select and pixel mux.
// Only instantiated when TEST_PATTERN_EN is defined.
module tpg_pattern
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF
) (
   input  logic        clk,
   input  logic        rst_p,
   input  logic [1:0]  pat_sel_i,
   input  logic        frame_org_i,
   input  logic        line_end_i,
   input  logic [7:0]  pix_x_i,
   input  logic [7:0]  pix_y_i,
   input  logic [7:0]  frame_cnt_i,
   output logic [23:0] rgb_o
);

   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
   localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

   logic [1:0]    sel_q, sel_eff;
   logic [2:0]    bar_q, bar_d;
   logic [CW-1:0] wcnt_q, wcnt_d;

   always_comb begin
      // Frame origin takes the live select so pixel (0,0) already uses it.
      sel_eff = frame_org_i ? pat_sel_i : sel_q;
      bar_d   = bar_q;
      wcnt_d  = wcnt_q + 1'b1;
      if (line_end_i) begin
         bar_d  = '0;
         wcnt_d = '0;
      end else if (wcnt_q == BAR_LAST) begin
         wcnt_d = '0;
         if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
      end

      rgb_o = '0;
      case (sel_eff)
         PAT_BARS:  rgb_o = BAR_RGB[bar_q];
         PAT_GRAD:  rgb_o = {pix_x_i, pix_y_i, frame_cnt_i};
         PAT_CHECK: rgb_o = (pix_x_i[5] ^ pix_y_i[5]) ? 24'hFFFFFF : 24'h000000;
         PAT_WHITE: rgb_o = 24'hFFFFFF;
         default:   rgb_o = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         sel_q  <= PAT_BARS;
         bar_q  <= '0;
         wcnt_q <= '0;
      end else begin
         sel_q  <= sel_eff;
         bar_q  <= bar_d;
         wcnt_q <= wcnt_d;
      end
   end

endmodule

// File: rtl/hdmi_video_timing.sv
// Video timing generator and pixel source feeding the three TMDS encoders.
// TEST_PATTERN_EN selects the internal pattern generator instead of the rgb_in pixel port.
module hdmi_video_timing
   import hdmi_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic          clk,
   input  logic          rst_p,
`ifdef TEST_PATTERN_EN
   input  logic [1:0]    pat_sel,
`else
   input  logic [23:0]   rgb_in,
`endif
   output logic          pix_req,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start,
   output logic [7:0]    r,
   output logic [7:0]    g,
   output logic [7:0]    b
);

   localparam logic [CW-1:0] HE_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] HE_FP   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HE_SYNC = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CW-1:0] VE_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] VE_FP   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VE_SYNC = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   h_state_e      h_state_q, h_state_d;
   logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          gate_q;
   logic          line_end, frame_end, pix_act, frame_org, v_sync_ph;
   logic [23:0]   pix_rgb;
   logic          de_q, hsync_q, vsync_q, fs_q;
   logic [23:0]   rgb_q;

   always_comb begin
      line_end    = (h_cnt_q == H_LAST);
      frame_end   = line_end && (v_cnt_q == V_LAST);
      h_cnt_d     = line_end ? '0 : h_cnt_q + 1'b1;
      v_cnt_d     = v_cnt_q;
      if (frame_end)     v_cnt_d = '0;
      else if (line_end) v_cnt_d = v_cnt_q + 1'b1;
      frame_cnt_d = frame_end ? frame_cnt_q + 8'd1 : frame_cnt_q;
      h_state_d   = phase_of(h_cnt_d, HE_ACT, HE_FP, HE_SYNC);
      pix_act     = (h_state_q == ST_ACTIVE) && (v_cnt_q < VE_ACT);
      frame_org   = (h_cnt_q == '0) && (v_cnt_q == '0);
      v_sync_ph   = (phase_of(v_cnt_q, VE_ACT, VE_FP, VE_SYNC) == ST_SYNC);
   end

`ifdef TEST_PATTERN_EN
   tpg_pattern #(.H_ACTIVE(H_ACTIVE)) u_tpg (
      .clk         (clk),
      .rst_p       (rst_p),
      .pat_sel_i   (pat_sel),
      .frame_org_i (frame_org),
      .line_end_i  (line_end),
      .pix_x_i     (h_cnt_q[7:0]),
      .pix_y_i     (v_cnt_q[7:0]),
      .frame_cnt_i (frame_cnt_q),
      .rgb_o       (pix_rgb)
   );
`else
   assign pix_rgb = rgb_in;
`endif

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         h_state_q   <= ST_ACTIVE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
         gate_q      <= 1'b0;
         de_q        <= 1'b0;
         hsync_q     <= ~HS_POL;
         vsync_q     <= ~VS_POL;
         fs_q        <= 1'b0;
         rgb_q       <= '0;
      end else begin
         h_state_q   <= h_state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         gate_q      <= 1'b1;
         de_q        <= pix_act;
         hsync_q     <= (h_state_q == ST_SYNC) ? HS_POL : ~HS_POL;
         vsync_q     <= v_sync_ph ? VS_POL : ~VS_POL;
         fs_q        <= frame_org;
         rgb_q       <= pix_act ? pix_rgb : '0;
      end
   end

   // pix_req stays low through reset even though the counters already sit on (0,0).
   assign pix_req     = gate_q && pix_act;
   assign pix_x       = h_cnt_q;
   assign pix_y       = v_cnt_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = fs_q;
   assign {r, g, b}   = rgb_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Self-checking bench for hdmi_video_timing with small timing (H 8/2/3/3, V 4/1/2/1);
// covers the rgb_in build by default and the pattern build when TEST_PATTERN_EN is defined.
module tb_hdmi_video_timing;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int BW = HA / 8;

   logic        clk = 1'b0;
   logic        rst_p = 1'b1;
`ifdef TEST_PATTERN_EN
   logic [1:0]  pat_sel = 2'b00;
   logic [1:0]  sel_frm = 2'b00;
`else
   logic [23:0] rgb_in = '0;
`endif
   logic        pix_req, de, hsync, vsync, frame_start;
   logic [10:0] pix_x, pix_y;
   logic [7:0]  r, g, b;

   int total = 0;
   int bad   = 0;
   int edges = -1;
   logic [23:0] rgb_smp = '0;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   hdmi_video_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk         (clk),
      .rst_p       (rst_p),
`ifdef TEST_PATTERN_EN
      .pat_sel     (pat_sel),
`else
      .rgb_in      (rgb_in),
`endif
      .pix_req     (pix_req),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .de          (de),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .r           (r),
      .g           (g),
      .b           (b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d, t=%0t)", nm, act, exp, edges, $time);
      end
   endtask

   task automatic check_reset();
      chk("rst_de", de, 0);
      chk("rst_pix_req", pix_req, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_pix_x", pix_x, 0);
      chk("rst_pix_y", pix_y, 0);
      chk("rst_frame_cnt", dut.frame_cnt_q, 0);
   endtask

   // Pixel that must appear for raster position (x,y) of frame number fc.
   function automatic logic [23:0] exp_rgb(input int x, input int y, input int fc);
      logic [23:0] v;
`ifdef TEST_PATTERN_EN
      int bi;
      case (sel_frm)
         2'b00: begin
            bi = x / BW;
            if (bi > 7) bi = 7;
            v = bars[bi];
         end
         2'b01: v = {8'(x), 8'(y), 8'(fc)};
         2'b10: v = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: v = 24'hFFFFFF;
      endcase
`else
      v = (fc >= 0) ? rgb_smp : rgb_smp;
      v = v + 24'(x * 0) + 24'(y * 0);
`endif
      return v;
   endfunction

   // Outputs after edge k show raster position k; counters already hold position k+1.
   task automatic check_model(input int k);
      int p, x, y, pn, xn, yn;
      logic act;
      p  = k % FT;  x  = p % HT;  y  = p / HT;
      pn = (k + 1) % FT; xn = pn % HT; yn = pn / HT;
      act = (x < HA) && (y < VA);
      chk("de", de, act);
      chk("hsync", hsync, !((x >= HA + HF) && (x < HA + HF + HS)));
      chk("vsync", vsync, !((y >= VA + VF) && (y < VA + VF + VS)));
      chk("frame_start", frame_start, p == 0);
      chk("pix_x", pix_x, xn);
      chk("pix_y", pix_y, yn);
      chk("pix_req", pix_req, (xn < HA) && (yn < VA));
      chk("rgb", {r, g, b}, act ? exp_rgb(x, y, (k / FT) % 256) : 24'h0);
      chk("frame_cnt", dut.frame_cnt_q, ((k + 1) / FT) % 256);
      case (k)
         0:     begin chk("lit_first_de", de, 1); chk("lit_first_fs", frame_start, 1); end
         7:     chk("lit_de_last", de, 1);
         8:     chk("lit_de_off", de, 0);
         10:    chk("lit_hs_start", hsync, 0);
         12:    chk("lit_hs_end", hsync, 0);
         13:    chk("lit_hs_off", hsync, 1);
         79:    chk("lit_vs_before", vsync, 1);
         80:    chk("lit_vs_start", vsync, 0);
         111:   chk("lit_vs_last", vsync, 0);
         112:   chk("lit_vs_off", vsync, 1);
         127:   chk("lit_fs_gap", frame_start, 0);
         128:   chk("lit_fs_period", frame_start, 1);
         32766: chk("lit_fc_255", dut.frame_cnt_q, 255);
         32767: chk("lit_fc_wrap", dut.frame_cnt_q, 0);
         default: ;
      endcase
`ifdef TEST_PATTERN_EN
      if (sel_frm == 2'b00 && y == 0 && x < HA)
         chk("lit_bar", {r, g, b}, bars[x]);
`endif
   endtask

   always @(posedge clk) begin
      if (rst_p) edges = -1;
      else begin
         edges++;
`ifdef TEST_PATTERN_EN
         if (edges % FT == 0) sel_frm = pat_sel;
`else
         rgb_smp = rgb_in;
`endif
      end
   end

   always @(negedge clk) begin
      if (rst_p || edges < 0) check_reset();
      else check_model(edges);
   end

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
`ifdef TEST_PATTERN_EN
         if ($urandom_range(0, 39) == 0) pat_sel = 2'($urandom_range(0, 3));
`else
         rgb_in = 24'($urandom);
`endif
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #3 rst_p = 1'b0;
      run(33000);
      repeat (5) @(posedge clk);
      #3 rst_p = 1'b1;
      #1 check_reset();
      repeat (3) @(posedge clk);
      #3 rst_p = 1'b0;
      run(400);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hdmi_video_timing.md
# hdmi_video_timing

Single-clock video timing and pixel source that drives the three TMDS encoder channels of the HDMI transmitter. It generates horizontal/vertical sync, data-enable and 24-bit RGB pixels in pixel-clock domain, all registered and mutually aligned, so `de`, `hsync`, `vsync` and each 8-bit colour feed the encoder's `de`, `c0`, `c1` and `din` inputs directly. Channel 0 (blue) carries `hsync`/`vsync` on `c0`/`c1`. Channels 1 and 2 tie `c0`/`c1` low.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `clk` in 1: pixel clock, rising edge
- `rst_p` in 1: asynchronous, active-high reset
- `pat_sel` in 2: test pattern select (`TEST_PATTERN_EN` only)
- `rgb_in` in 24: external pixel {R,G,B} (without `TEST_PATTERN_EN` only)
- `pix_req` out 1: counters are in the active region; the pixel for (`pix_x`,`pix_y`) is consumed this cycle
- `pix_x` out 11: current horizontal counter
- `pix_y` out 11: current vertical counter
- `de` out 1: data enable to encoders
- `hsync` out 1: horizontal sync, polarity `HS_POL`
- `vsync` out 1: vertical sync, polarity `VS_POL`
- `frame_start` out 1: one-cycle pulse with the first active pixel of each frame
- `r`, `g`, `b` out 8 each: pixel to encoder `din`

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Horizontal FSM states: ACTIVE → FP → SYNC → BP → ACTIVE. Each state lasts its parameter length, tracked by `h_cnt` from 0 to H_TOTAL-1. A zero-length state is skipped.
- At the end of BP, `h_cnt` wraps to 0 and `v_cnt` increments. At V_TOTAL-1, `v_cnt` wraps to 0.
- Vertical phases are decoded from `v_cnt`: ACTIVE when below V_ACTIVE, then FP, SYNC, BP.
- `pix_req` = (h state ACTIVE) && (v_cnt < V_ACTIVE). `pix_x`/`pix_y` are the raw counter registers.
- Registered outputs at edge n+1 reflect the counter state at edge n:
  - `de` equals the previous `pix_req`.
  - `hsync` is active while h state is SYNC. `vsync` is active while the v phase is SYNC, with transitions at `h_cnt`=0.
  - `frame_start` is the previous (`h_cnt`==0 && `v_cnt`==0).
- `r`/`g`/`b` are forced to 0 whenever `de` is 0.
- An 8-bit `frame_cnt` increments on each wrap of `v_cnt` and wraps 255→0.
- Reset values:
  - counters 0, FSM ACTIVE, `frame_cnt` 0.
  - `de`=0, `pix_req`=0 (registered gate), `frame_start`=0.
  - `hsync`=~HS_POL, `vsync`=~VS_POL, `r`/`g`/`b`=0.
- Reset mid-frame aborts immediately. After release, the first edge outputs pixel (0,0) with `frame_start`=1 and `de`=1.

## Timing
- Counter-to-output latency is 1 cycle. `de`, the syncs and the RGB outputs are always aligned in the same cycle.
- The encoder adds its own 2-cycle alignment, so no skew compensation is needed here.
- Without the macro, `rgb_in` is sampled at the edge ending a `pix_req` cycle and appears on `r`/`g`/`b` together with `de` one cycle later.
- Line period is exactly H_TOTAL cycles. Frame period is exactly H_TOTAL×V_TOTAL cycles.

## Configuration
- `TEST_PATTERN_EN` defined: `pat_sel` is present and `rgb_in` is absent. Pixels are generated internally.
  - `pat_sel` is sampled only when `h_cnt`=0 and `v_cnt`=0, so a pattern never changes mid-frame.
  - 00: 8 colour bars, each BAR_W=H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The bar index advances via a bar-width counter; no divider is used.
  - 01: gradient, R=`pix_x`[7:0], G=`pix_y`[7:0], B=`frame_cnt`.
  - 10: 32-pixel checkerboard, white when `pix_x`[5]^`pix_y`[5] is 1, else black.
  - 11: solid white.
- `TEST_PATTERN_EN` undefined: `rgb_in` is present and `pat_sel` is absent. The pattern logic is not built.

## Structure
- Shared package `hdmi_pkg` holds:
  - the 640×480@60 default timing constants;
  - the H-state enum;
  - the `pat_sel` encodings;
  - the 8-entry colour-bar 24-bit constant table.
- One sub-module, `tpg_pattern`, holds the bar counter, the pattern mux and `frame_cnt` usage. It is instantiated only under `TEST_PATTERN_EN`.

## Test plan
All scenarios use small timing: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), with `HS_POL`=0.
- Reset, then release: the first output cycle has `de`=1 and `frame_start`=1. `de` is high for 8 cycles, then low for 8.
- `hsync`: low for exactly 3 cycles, starting 10 cycles after the first `de` of each line. `vsync` is low for 2 line periods starting at output line 5.
- Frame length: `frame_start` pulses are exactly 128 cycles apart. `frame_cnt` wraps 255→0 after 256 frames.
- `pat_sel`=00 with H_ACTIVE=8: pixels on the first line are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. RGB is 0 on every `de`=0 cycle.
- `pat_sel` changed mid-frame: the output pattern is unchanged until the next `frame_start`.
- `rst_p` asserted mid-line: all outputs immediately take their reset values. Restart is clean from (0,0).
